// File: rtl/instruction_decode_pkg.sv
// instruction_decode_pkg: opcode/funct constants and control bundle for the ID stage
package instruction_decode_pkg;
  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2b;
  localparam logic [5:0] OP_HALT   = 6'h3f;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dst;
    logic link;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (op)
      OP_R_TYPE: begin
        c.reg_write = funct != FN_JR;
        c.reg_dst   = funct != FN_JR;
        c.link      = funct == FN_JALR;
      end
      OP_JAL: begin
        c.reg_write = 1'b1;
        c.link      = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_LW, OP_LH, OP_LB, OP_LHU, OP_LBU: begin
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
      end
      OP_SW, OP_SH, OP_SB: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic reads_rt(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_R_TYPE && funct != FN_JR && funct != FN_JALR) ||
           op == OP_BEQ || op == OP_BNE || op == OP_SW || op == OP_SH || op == OP_SB;
  endfunction
endpackage

// File: rtl/instruction_decode_register_file.sv
// register_file: 32x32 regfile, two async write-first reads, one sync write, r0 hardwired to zero
module register_file #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               we,
  input  logic [NB_REG-1:0]  wr_addr,
  input  logic [NB_DATA-1:0] wr_data,
  input  logic [NB_REG-1:0]  rd_addr_a,
  input  logic [NB_REG-1:0]  rd_addr_b,
  output logic [NB_DATA-1:0] rd_data_a,
  output logic [NB_DATA-1:0] rd_data_b
);
  logic [NB_DATA-1:0] regs [2**NB_REG];

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2**NB_REG; i++) regs[i] <= '0;
    end else if (we && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = rd_addr_a == '0 ? '0 : (we && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
  assign rd_data_b = rd_addr_b == '0 ? '0 : (we && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: ID stage with regfile, control decode, in-ID jump/branch resolve, hazard stall and ID/EX register
module instruction_decode
  import instruction_decode_pkg::*;
#(
  parameter int          NB_DATA     = 32,
  parameter int          NB_REG      = 5,
  parameter logic [5:0]  HALT_OPCODE = OP_HALT
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [31:0]        i_instruction,
  input  logic [NB_DATA-1:0] i_pcounter,
  input  logic               i_wb_we,
  input  logic [NB_REG-1:0]  i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data,
  input  logic               i_ex_reg_write,
  input  logic               i_ex_mem_read,
  input  logic [NB_REG-1:0]  i_ex_wr_addr,
  input  logic               i_mem_mem_read,
  input  logic [NB_REG-1:0]  i_mem_wr_addr,
  output logic               o_stall,
  output logic               o_jump,
  output logic [NB_DATA-1:0] o_addr2jump,
  output logic               o_halt,
  output logic [NB_DATA-1:0] o_rs_data,
  output logic [NB_DATA-1:0] o_rt_data,
  output logic [NB_DATA-1:0] o_imm_ext,
  output logic [NB_REG-1:0]  o_rs,
  output logic [NB_REG-1:0]  o_rt,
  output logic [NB_REG-1:0]  o_rd,
  output logic [4:0]         o_shamt,
  output logic [5:0]         o_funct,
  output logic [5:0]         o_opcode,
  output logic [NB_DATA-1:0] o_pcounter,
  output logic               o_reg_write,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_mem_to_reg,
  output logic               o_alu_src,
  output logic               o_reg_dst,
  output logic               o_link
);
  logic [5:0]         op, funct;
  logic [NB_REG-1:0]  rs, rt, rd;
  logic [4:0]         shamt;
  logic [15:0]        imm;
  logic [NB_DATA-1:0] rs_data, rt_data, imm_ext;
  logic               is_halt, is_j, is_jr, is_br, use_rt, ld_use, br_use, br_ld, taken;
  ctrl_t              ctrl;

  assign op    = i_instruction[31:26];
  assign rs    = i_instruction[25:21];
  assign rt    = i_instruction[20:16];
  assign rd    = i_instruction[15:11];
  assign shamt = i_instruction[10:6];
  assign funct = i_instruction[5:0];
  assign imm   = i_instruction[15:0];

  register_file #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) u_register_file (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .we        (i_wb_we),
    .wr_addr   (i_wb_addr),
    .wr_data   (i_wb_data),
    .rd_addr_a (rs),
    .rd_addr_b (rt),
    .rd_data_a (rs_data),
    .rd_data_b (rt_data)
  );

  assign is_halt = op == HALT_OPCODE;
  assign ctrl    = is_halt ? '0 : decode_ctrl(op, funct);
  assign use_rt  = reads_rt(op, funct);
  assign is_j    = op == OP_J || op == OP_JAL;
  assign is_jr   = op == OP_R_TYPE && (funct == FN_JR || funct == FN_JALR);
  assign is_br   = op == OP_BEQ || op == OP_BNE;
  assign imm_ext = op == OP_LUI ? {imm, 16'b0} :
                   (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ? {{(NB_DATA-16){1'b0}}, imm} :
                   {{(NB_DATA-16){imm[15]}}, imm};
  assign ld_use  = i_ex_mem_read && i_ex_wr_addr != '0 &&
                   (i_ex_wr_addr == rs || (use_rt && i_ex_wr_addr == rt));
  // branch compare happens here in ID, so any in-flight producer of a source must drain first
  assign br_use  = (is_br || is_jr) && i_ex_reg_write && i_ex_wr_addr != '0 &&
                   (i_ex_wr_addr == rs || (is_br && i_ex_wr_addr == rt));
  assign br_ld   = (is_br || is_jr) && i_mem_mem_read && i_mem_wr_addr != '0 &&
                   (i_mem_wr_addr == rs || (is_br && i_mem_wr_addr == rt));
  assign o_stall = ld_use || br_use || br_ld;
  assign taken   = is_j || is_jr || (op == OP_BEQ && rs_data == rt_data) || (op == OP_BNE && rs_data != rt_data);
  assign o_jump  = taken && !o_stall && !o_halt;
  assign o_addr2jump = is_j ? {i_pcounter[NB_DATA-1:26], i_instruction[25:0]} :
                       is_jr ? rs_data : i_pcounter + NB_DATA'(1) + imm_ext;

  always_ff @(posedge clk) begin
    if (!i_rst_n || (!o_halt && o_stall)) begin
      o_halt     <= 1'b0;
      o_rs_data  <= '0;
      o_rt_data  <= '0;
      o_imm_ext  <= '0;
      o_rs       <= '0;
      o_rt       <= '0;
      o_rd       <= '0;
      o_shamt    <= '0;
      o_funct    <= '0;
      o_opcode   <= '0;
      o_pcounter <= '0;
      {o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst, o_link} <= 7'b0;
    end else if (!o_halt) begin
      o_halt     <= is_halt;
      o_rs_data  <= rs_data;
      o_rt_data  <= rt_data;
      o_imm_ext  <= imm_ext;
      o_rs       <= rs;
      o_rt       <= rt;
      o_rd       <= rd;
      o_shamt    <= shamt;
      o_funct    <= funct;
      o_opcode   <= op;
      o_pcounter <= i_pcounter + NB_DATA'(2);
      {o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst, o_link} <= ctrl;
    end
  end
endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed vectors with a cycle-tagged scoreboard checked by an independent monitor
module tb_instruction_decode;
  import instruction_decode_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_instruction, i_pcounter, i_wb_data;
  logic        i_wb_we, i_ex_reg_write, i_ex_mem_read, i_mem_mem_read;
  logic [4:0]  i_wb_addr, i_ex_wr_addr, i_mem_wr_addr;
  logic        o_stall, o_jump, o_halt;
  logic [31:0] o_addr2jump, o_rs_data, o_rt_data, o_imm_ext, o_pcounter;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [5:0]  o_funct, o_opcode;
  logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst, o_link;

  instruction_decode dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_instruction(i_instruction), .i_pcounter(i_pcounter),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_ex_reg_write(i_ex_reg_write), .i_ex_mem_read(i_ex_mem_read), .i_ex_wr_addr(i_ex_wr_addr),
    .i_mem_mem_read(i_mem_mem_read), .i_mem_wr_addr(i_mem_wr_addr),
    .o_stall(o_stall), .o_jump(o_jump), .o_addr2jump(o_addr2jump), .o_halt(o_halt),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm_ext(o_imm_ext),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt), .o_funct(o_funct),
    .o_opcode(o_opcode), .o_pcounter(o_pcounter),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_to_reg(o_mem_to_reg), .o_alu_src(o_alu_src), .o_reg_dst(o_reg_dst), .o_link(o_link)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef enum {S_STALL, S_JUMP, S_ADDR, S_HALT, S_RS, S_RT, S_IMM, S_CTRL, S_PC, S_RD} sig_e;
  typedef struct {
    int          cyc;
    string       name;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_STALL: return {31'b0, o_stall};
      S_JUMP:  return {31'b0, o_jump};
      S_ADDR:  return o_addr2jump;
      S_HALT:  return {31'b0, o_halt};
      S_RS:    return o_rs_data;
      S_RT:    return o_rt_data;
      S_IMM:   return o_imm_ext;
      S_CTRL:  return {25'b0, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst, o_link};
      S_PC:    return o_pcounter;
      default: return {27'b0, o_rd};
    endcase
  endfunction

  task automatic push(input int c, input string n, input sig_e s, input logic [31:0] v);
    exp_t e;
    int i;
    e = '{c, n, s, v};
    i = q.size();
    while (i > 0 && q[i-1].cyc > c) i--;
    q.insert(i, e);
  endtask

  task automatic now(input string n, input sig_e s, input logic [31:0] v);
    push(cyc, n, s, v);
  endtask

  task automatic nxt(input string n, input sig_e s, input logic [31:0] v);
    push(cyc + 1, n, s, v);
  endtask

  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        act = sample(e.sig);
        n_vec++;
        if (e.cyc != cyc || act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %h, expected %h (cycle %0d, due %0d)", e.name, act, e.exp, cyc, e.cyc);
        end
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {OP_R_TYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    i_wb_we = 0; i_wb_addr = 0; i_wb_data = 0;
    i_ex_reg_write = 0; i_ex_mem_read = 0; i_ex_wr_addr = 0;
    i_mem_mem_read = 0; i_mem_wr_addr = 0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    i_wb_we = 1; i_wb_addr = a; i_wb_data = d;
  endtask

  initial begin
    i_rst_n = 0; clr(); i_instruction = 0; i_pcounter = 0;
    tick();
    // reset clears ID/EX even with a live instruction on the input
    i_instruction = enc_r(5, 0, 1, FN_ADDU); i_pcounter = 4;
    nxt("rst_ctrl", S_CTRL, 0); nxt("rst_pc", S_PC, 0); nxt("rst_halt", S_HALT, 0); nxt("rst_rs", S_RS, 0);
    tick();
    i_rst_n = 1;
    wb(5, 32'hAA); i_instruction = 0;
    now("nop_stall", S_STALL, 0);
    tick();
    clr(); i_instruction = enc_r(5, 0, 1, FN_ADDU); i_pcounter = 4;
    now("addu_jump", S_JUMP, 0);
    nxt("addu_rs", S_RS, 32'hAA); nxt("addu_ctrl", S_CTRL, 32'h42); nxt("addu_rd", S_RD, 1); nxt("addu_pc", S_PC, 6);
    tick();
    wb(3, 32'h1234); i_instruction = enc_r(3, 0, 1, FN_ADDU);
    nxt("bypass_rs", S_RS, 32'h1234);
    tick();
    wb(0, 32'hFFFF_FFFF); i_instruction = enc_r(0, 0, 1, FN_ADDU);
    nxt("r0_bypass", S_RS, 0);
    tick();
    clr(); i_instruction = enc_r(0, 5, 1, FN_ADDU);
    nxt("r0_read", S_RS, 0); nxt("rt_read", S_RT, 32'hAA);
    tick();
    wb(1, 5); i_instruction = 0; tick();
    wb(2, 7); tick();
    wb(7, 32'h80); tick();
    clr();
    // load-use
    i_ex_mem_read = 1; i_ex_reg_write = 1; i_ex_wr_addr = 2;
    i_instruction = enc_r(2, 1, 4, FN_ADD); i_pcounter = 8;
    now("lu_stall", S_STALL, 1); now("lu_jump", S_JUMP, 0);
    nxt("lu_bub_ctrl", S_CTRL, 0); nxt("lu_bub_rs", S_RS, 0); nxt("lu_bub_pc", S_PC, 0); nxt("lu_bub_rd", S_RD, 0);
    tick();
    clr();
    now("lu_clear", S_STALL, 0);
    nxt("dec_rs", S_RS, 7); nxt("dec_rt", S_RT, 5); nxt("dec_ctrl", S_CTRL, 32'h42); nxt("dec_rd", S_RD, 4); nxt("dec_pc", S_PC, 10);
    tick();
    i_ex_mem_read = 1; i_ex_wr_addr = 0; i_instruction = enc_r(0, 0, 4, FN_ADD);
    now("lu_r0_nostall", S_STALL, 0);
    tick();
    clr();
    // branches and jumps
    i_instruction = enc_i(OP_BEQ, 1, 1, 16'hFFFE); i_pcounter = 32'h10;
    now("beq_stall", S_STALL, 0); now("beq_jump", S_JUMP, 1); now("beq_addr", S_ADDR, 32'h0F);
    nxt("beq_imm", S_IMM, 32'hFFFF_FFFE); nxt("beq_ctrl", S_CTRL, 0);
    tick();
    i_instruction = enc_i(OP_BNE, 1, 1, 16'hFFFE);
    now("bne_jump", S_JUMP, 0);
    tick();
    i_instruction = enc_j(OP_J, 26'h40); i_pcounter = 32'h20;
    now("j_jump", S_JUMP, 1); now("j_addr", S_ADDR, 32'h40);
    tick();
    i_ex_reg_write = 1; i_ex_wr_addr = 7; i_instruction = enc_r(7, 0, 0, FN_JR); i_pcounter = 32'h24;
    now("jr_stall0", S_STALL, 1); now("jr_jump0", S_JUMP, 0);
    tick();
    now("jr_stall1", S_STALL, 1); now("jr_jump1", S_JUMP, 0);
    tick();
    clr();
    now("jr_stall2", S_STALL, 0); now("jr_jump2", S_JUMP, 1); now("jr_addr", S_ADDR, 32'h80);
    tick();
    i_mem_mem_read = 1; i_mem_wr_addr = 2; i_instruction = enc_i(OP_BEQ, 2, 1, 16'h0);
    now("brld_stall", S_STALL, 1); now("brld_jump", S_JUMP, 0);
    tick();
    i_instruction = enc_r(2, 1, 4, FN_ADD);
    now("memld_alu_nostall", S_STALL, 0);
    tick();
    clr();
    wb(1, 7); i_instruction = enc_i(OP_BEQ, 1, 2, 16'h3); i_pcounter = 32'h30;
    now("beq_bypass_jump", S_JUMP, 1); now("beq_bypass_addr", S_ADDR, 32'h34);
    tick();
    clr();
    // immediates and memory controls
    i_instruction = enc_i(OP_ORI, 0, 3, 16'h8000);
    nxt("ori_imm", S_IMM, 32'h0000_8000); nxt("ori_ctrl", S_CTRL, 32'h44);
    tick();
    i_instruction = enc_i(OP_LUI, 0, 3, 16'h1234);
    nxt("lui_imm", S_IMM, 32'h1234_0000);
    tick();
    i_instruction = enc_i(OP_LW, 1, 6, 16'h0004);
    nxt("lw_ctrl", S_CTRL, 32'h6C); nxt("lw_imm", S_IMM, 4);
    tick();
    i_ex_mem_read = 1; i_ex_wr_addr = 6; i_instruction = enc_i(OP_SW, 1, 6, 16'h0004);
    now("sw_lu_stall", S_STALL, 1);
    tick();
    i_instruction = enc_i(OP_ADDI, 1, 6, 16'h0001);
    now("addi_rt_nostall", S_STALL, 0);
    tick();
    clr(); i_instruction = enc_i(OP_SW, 1, 6, 16'h0004);
    nxt("sw_ctrl", S_CTRL, 32'h14);
    tick();
    i_instruction = {6'b010000, 26'h0};
    nxt("unknown_ctrl", S_CTRL, 0);
    tick();
    // halt
    i_instruction = {OP_HALT, 26'h0}; i_pcounter = 32'h40;
    now("halt_jump", S_JUMP, 0);
    nxt("halt_set", S_HALT, 1); nxt("halt_ctrl", S_CTRL, 0); nxt("halt_pc", S_PC, 32'h42);
    tick();
    i_instruction = enc_r(5, 0, 1, FN_ADDU); i_pcounter = 32'h50;
    nxt("halt_sticky", S_HALT, 1); nxt("halt_frz_ctrl", S_CTRL, 0); nxt("halt_frz_pc", S_PC, 32'h42);
    tick();
    i_instruction = enc_j(OP_J, 26'h40);
    now("halt_nojump", S_JUMP, 0);
    nxt("halt_sticky2", S_HALT, 1);
    tick();
    i_rst_n = 0;
    nxt("rst2_halt", S_HALT, 0); nxt("rst2_ctrl", S_CTRL, 0); nxt("rst2_pc", S_PC, 0);
    nxt("rst2_rs", S_RS, 0); nxt("rst2_imm", S_IMM, 0);
    tick();
    i_rst_n = 1; i_instruction = enc_r(5, 0, 1, FN_ADDU); i_pcounter = 4;
    nxt("rf_cleared", S_RS, 0); nxt("post_rst_ctrl", S_CTRL, 32'h42); nxt("post_rst_halt", S_HALT, 0);
    tick();
    tick();
    tick();
    if (q.size() != 0) begin
      $display("FAIL pending: %0d checks never reached", q.size());
      n_bad += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
